seq_chunk_adder: RTL and testbench

- Parametrised multi-cycle successor to the fixed 4-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, through one shared CHUNK-bit ripple slice; the carry is held in a register between chunks.
- Honours carry/borrow-in, adds subtract mode, and reports carry-out and signed overflow.
- Sits between operand producers and consumers using valid/ready handshakes on both sides.

---
 rtl/seq_chunk_adder_pkg.sv | 19 +
 rtl/seq_chunk_adder_slice.sv | 56 +++++
 rtl/seq_chunk_adder.sv | 109 ++++++++++
 tb/tb_seq_chunk_adder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding and size helpers.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Guarded so an illegal CHUNK reaches the elaboration check instead of dividing by zero.
    function automatic int nchunk(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_slice.sv
// Combinational CHUNK-bit ripple slice built from full adders, themselves built from half adders.
// c_msb is the carry into the top bit, needed by the parent for signed overflow.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
    half_adder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

    assign cout = c1 | c2;
endmodule

module ripple_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);
    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (s[i]),
            .cout (carry[i+1])
        );
    end

    assign cout  = carry[CHUNK];
    assign c_msb = carry[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract of two WIDTH-bit operands, CHUNK bits per clock through one shared slice.
// Result valid WIDTH/CHUNK clocks after acceptance; no overlap, in_ready low until the result is taken.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_width(NCHUNK);

    if ((CHUNK < 1) ? 1'b1 : ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $fatal(1, "seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IW-1:0]    idx;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_s;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             last_chunk;

    assign slice_a    = a_r[int'(idx)*CHUNK +: CHUNK];
    assign slice_b    = b_r[int'(idx)*CHUNK +: CHUNK];
    assign last_chunk = (idx == IW'(NCHUNK - 1));

    ripple_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_r),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    // Subtraction is a + ~b + 1, so borrow-in folds into the initial carry as cin ^ sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            ovf       <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            carry_r   <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= sub ? ~b : b;
                        carry_r  <= cin ^ sub;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[int'(idx)*CHUNK +: CHUNK] <= slice_s;
                    carry_r                       <= slice_cout;
                    if (last_chunk) begin
                        sum[WIDTH] <= slice_cout;
                        ovf        <= slice_cout ^ slice_cmsb;
                        out_valid  <= 1'b1;
                        idx        <= '0;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: CHUNK=1/4/16 instances at WIDTH=16, checked against an integer model.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [16:0] sum_w     [3];
    logic        ovf_w     [3];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        seq_chunk_adder #(
            .WIDTH (16),
            .CHUNK ((g == 0) ? 1 : ((g == 1) ? 4 : 16))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .sum       (sum_w[g]),
            .ovf       (ovf_w[g])
        );
    end

    function automatic int nch(input int k);
        return (k == 0) ? 16 : ((k == 1) ? 4 : 1);
    endfunction

    // Model: exact integer result, then reduce to 16 bits plus carry/no-borrow and signed range test.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        int          ux = int'(x);
        int          uy = int'(y);
        int          sx = int'($signed(x));
        int          sy = int'($signed(y));
        int          ci = c ? 1 : 0;
        int          r;
        int          sr;
        logic        top;
        logic [31:0] rv;
        if (!s) begin
            r   = ux + uy + ci;
            sr  = sx + sy + ci;
            top = (r >= 65536);
        end else begin
            r   = ux - uy - ci;
            sr  = sx - sy - ci;
            top = (r >= 0);
        end
        rv = r;
        return {(sr > 32767) || (sr < -32768), top, rv[15:0]};
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (t=%0t)", nm, k, act, exp, $time);
        end
    endtask

    // Single compare process: records acceptances, then checks the result, latency and stability.
    bit          busy     [3];
    bit          seen     [3];
    logic [16:0] exp_sum  [3];
    logic        exp_ovf  [3];
    int          acc_cyc  [3];
    logic [16:0] held_sum [3];
    logic        held_ovf [3];
    logic [17:0] m;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                busy[k] = 1'b0;
                seen[k] = 1'b0;
            end else begin
                if (busy[k] && in_ready[k]) begin
                    miscompares++;
                    $display("FAIL in_ready_while_busy dut%0d: got 1 expected 0 (t=%0t)", k, $time);
                end
                if (in_valid[k] && in_ready[k] && !busy[k]) begin
                    m          = model(a, b, cin, sub);
                    exp_sum[k] = m[16:0];
                    exp_ovf[k] = m[17];
                    acc_cyc[k] = cyc + 1;
                    busy[k]    = 1'b1;
                end
                if (out_valid[k]) begin
                    if (!busy[k]) begin
                        miscompares++;
                        $display("FAIL spurious_out_valid dut%0d: got 1 expected 0 (t=%0t)", k, $time);
                    end else if (!seen[k]) begin
                        chk("sum", k, 32'(sum_w[k]), 32'(exp_sum[k]));
                        chk("ovf", k, 32'(ovf_w[k]), 32'(exp_ovf[k]));
                        chk("latency", k, 32'(cyc - acc_cyc[k]), 32'(nch(k)));
                        held_sum[k] = sum_w[k];
                        held_ovf[k] = ovf_w[k];
                        seen[k]     = 1'b1;
                    end else begin
                        chk("sum_stable", k, 32'(sum_w[k]), 32'(held_sum[k]));
                        chk("ovf_stable", k, 32'(ovf_w[k]), 32'(held_ovf[k]));
                    end
                    if (out_ready[k]) begin
                        busy[k] = 1'b0;
                        seen[k] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_sig(input int k, input bit want_valid, input logic val, input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (((want_valid ? out_valid[k] : in_ready[k])) === val) hit = 1'b1;
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL %s dut%0d: timeout waiting for %0b", nm, k, val);
        end
    endtask

    task automatic op(input int k, input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      input logic ts, input int hold, input bit lit,
                      input logic [16:0] es, input logic eo);
        @(posedge clk);
        #1;
        a            = ta;
        b            = tb;
        cin          = tc;
        sub          = ts;
        out_ready[k] = (hold == 0);
        in_valid[k]  = 1'b1;
        wait_sig(k, 1'b0, 1'b1, "accept");
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        a           = ~ta;
        b           = ~tb;
        cin         = ~tc;
        sub         = ~ts;
        wait_sig(k, 1'b1, 1'b1, "result");
        if (lit) begin
            chk("lit_sum", k, 32'(sum_w[k]), 32'(es));
            chk("lit_ovf", k, 32'(ovf_w[k]), 32'(eo));
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            in_valid[k] = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                chk("bp_in_ready", k, 32'(in_ready[k]), 32'd0);
                chk("bp_out_valid", k, 32'(out_valid[k]), 32'd1);
            end
            @(posedge clk);
            #1;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        wait_sig(k, 1'b1, 1'b0, "handshake");
        chk("ready_after_done", k, 32'(in_ready[k]), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 1, 32'(in_ready[1]), 32'd0);
        chk("rst_out_valid", 1, 32'(out_valid[1]), 32'd0);
        chk("rst_sum", 1, 32'(sum_w[1]), 32'd0);
        chk("rst_ovf", 1, 32'(ovf_w[1]), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", 1, 32'(in_ready[1]), 32'd1);

        // Pin the model itself against hand-computed values.
        chk("model_add", 0, 32'(model(16'h1234, 16'h4321, 1'b0, 1'b0)), 32'h05555);
        chk("model_sub_ovf", 0, 32'(model(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'h37FFF);

        op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1, 17'h05555, 1'b0);
        op(1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1, 17'h10000, 1'b0);
        op(1, 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1, 17'h0FFFE, 1'b0);
        op(1, 16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1, 17'h10001, 1'b0);
        op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1, 17'h08000, 1'b1);
        op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1, 17'h17FFF, 1'b1);

        // Reset in the middle of RUN must discard the operation.
        @(posedge clk);
        #1;
        a           = 16'hABCD;
        b           = 16'h1111;
        in_valid[1] = 1'b1;
        wait_sig(1, 1'b0, 1'b1, "accept_mid_rst");
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 1, 32'(out_valid[1]), 32'd0);
        chk("midrst_sum", 1, 32'(sum_w[1]), 32'd0);
        chk("midrst_in_ready", 1, 32'(in_ready[1]), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_release_in_ready", 1, 32'(in_ready[1]), 32'd1);
        chk("midrst_release_out_valid", 1, 32'(out_valid[1]), 32'd0);
        repeat (8) @(negedge clk);
        chk("midrst_no_stale", 1, 32'(out_valid[1]), 32'd0);

        op(1, 16'h00FF, 16'h0F01, 1'b0, 1'b0, 10, 1, 17'h01000, 1'b0);
        op(1, 16'h0001, 16'h0002, 1'b1, 1'b0, 0, 1, 17'h00004, 1'b0);

        op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1, 17'h05555, 1'b0);
        op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 3, 1, 17'h17FFF, 1'b1);
        op(2, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1, 17'h10000, 1'b0);
        op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1, 17'h08000, 1'b1);

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 1000; n++) begin
                op(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0, 0, 17'h0, 1'b0);
            end
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
